// File: rtl/pad_pair_collector_if.sv
// Generation-pipe handshake plus pair-FIFO pop side of the pad pair collector.
// slave is the collector's view; master is the driving environment.
interface pad_pair_collector_if #(
  parameter int AW = 2
);
  logic [159:0] iopad_hash;
  logic         pad_type;
  logic         ready;
  logic         gen_finished;
  logic         hash_read;
  logic [319:0] pair_data;
  logic [31:0]  pair_id;
  logic         pair_valid;
  logic         pair_read;
  logic [AW:0]  fifo_count;
  logic         order_error;
  logic         drained;

  modport slave (
    input  iopad_hash, pad_type, ready, gen_finished, pair_read,
    output hash_read, pair_data, pair_id, pair_valid, fifo_count, order_error, drained
  );

  modport master (
    output iopad_hash, pad_type, ready, gen_finished, pair_read,
    input  hash_read, pair_data, pair_id, pair_valid, fifo_count, order_error, drained
  );
endinterface

// File: rtl/pad_pair_collector.sv
// Pairs ipad/opad midstates from the generation pipe into a show-ahead FIFO,
// acknowledging each midstate with a registered 4-phase hash_read.
module pad_pair_collector #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic                  clk,
  input logic                  device_reset_n,
  pad_pair_collector_if.slave  bus
);
  typedef enum logic {WAIT, ACK} state_t;

  state_t        state, state_nxt;
  logic          expect_opad;
  logic [159:0]  ipad_hold;
  logic [31:0]   id_cnt;
  logic [319:0]  mem_data [DEPTH];
  logic [31:0]   mem_id   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          order_error, drained;
  logic          full, push, pop, take_ipad, set_err;

  // Fullness uses the registered count, so a same-cycle pop never frees a slot.
  assign full = (count == (AW+1)'(DEPTH));
  assign pop  = bus.pair_read && (count != '0);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    take_ipad = 1'b0;
    set_err   = 1'b0;
    case (state)
      WAIT: if (bus.ready) begin
        if (!bus.pad_type) begin
          take_ipad = 1'b1;
          set_err   = expect_opad;
          state_nxt = ACK;
        end else if (!expect_opad) begin
          set_err   = 1'b1;
          state_nxt = ACK;
        end else if (!full) begin
          push      = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: if (!bus.ready) state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!device_reset_n) state <= WAIT;
    else                 state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!device_reset_n) begin
      expect_opad <= 1'b0;
      id_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      order_error <= 1'b0;
      drained     <= 1'b0;
    end else begin
      if (take_ipad) expect_opad <= 1'b1;
      else if (push) expect_opad <= 1'b0;
      if (set_err) order_error <= 1'b1;
      if (push) begin
        id_cnt <= id_cnt + 32'd1;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      drained <= bus.gen_finished && (count == '0) && (state == WAIT) &&
                 !expect_opad && !bus.ready;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (take_ipad) ipad_hold <= bus.iopad_hash;
    if (push) begin
      mem_data[wr_ptr] <= {ipad_hold, bus.iopad_hash};
      mem_id[wr_ptr]   <= id_cnt;
    end
  end

  assign bus.hash_read   = (state == ACK);
  assign bus.pair_data   = mem_data[rd_ptr];
  assign bus.pair_id     = mem_id[rd_ptr];
  assign bus.pair_valid  = (count != '0);
  assign bus.fifo_count  = count;
  assign bus.order_error = order_error;
  assign bus.drained     = drained;
endmodule

// File: tb/tb_pad_pair_collector.sv
// Directed plus randomized bench for pad_pair_collector with a queue-based pair model.
module tb_pad_pair_collector;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic [319:0] d;
    logic [31:0]  id;
  } pair_t;

  logic clk = 1'b0;
  logic device_reset_n = 1'b0;
  always #5 clk = ~clk;

  pad_pair_collector_if #(.AW(AW)) bus ();
  pad_pair_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .device_reset_n(device_reset_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  pair_t        mq[$];
  logic         m_exp = 1'b0;
  logic         m_err = 1'b0;
  logic [159:0] m_hold = '0;
  logic [31:0]  m_id = '0;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] rnd160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_exp = 1'b0; m_err = 1'b0; m_id = '0;
  endtask

  task automatic model_accept(input logic [159:0] h, input logic t);
    pair_t p;
    if (!t) begin
      if (m_exp) m_err = 1'b1;
      m_hold = h;
      m_exp  = 1'b1;
    end else if (m_exp) begin
      p.d = {m_hold, h};
      p.id = m_id;
      mq.push_back(p);
      m_id  = m_id + 32'd1;
      m_exp = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":count"}, bus.fifo_count, mq.size());
    chk({tag, ":valid"}, bus.pair_valid, mq.size() != 0);
    chk({tag, ":oerr"}, bus.order_error, m_err);
    if (mq.size() != 0) begin
      chk({tag, ":data"}, bus.pair_data, mq[0].d);
      chk({tag, ":id"}, bus.pair_id, mq[0].id);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic release_pad();
    bus.ready = 1'b0;
    @(negedge clk);
    chk("ack_release", bus.hash_read, 1'b0);
  endtask

  task automatic send_pad(input logic [159:0] h, input logic t);
    bit acked = 0;
    bus.iopad_hash = h; bus.pad_type = t; bus.ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.hash_read) begin acked = 1; break; end
    end
    chk("ack_seen", acked, 1'b1);
    if (acked) model_accept(h, t);
    release_pad();
  endtask

  task automatic pop_one();
    check_state("pre_pop");
    bus.pair_read = 1'b1;
    @(negedge clk);
    bus.pair_read = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check_state("post_pop");
  endtask

  task automatic do_reset();
    device_reset_n = 1'b0; bus.ready = 1'b0; bus.pair_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    device_reset_n = 1'b1;
  endtask

  logic [159:0] a_v, b_v, c_v, g_v;
  logic [31:0]  prev_id;
  bit           acked;
  logic         t;

  initial begin
    bus.iopad_hash = '0; bus.pad_type = 1'b0; bus.ready = 1'b0;
    bus.gen_finished = 1'b0; bus.pair_read = 1'b0;
    do_reset();
    chk("rst_hash_read", bus.hash_read, 1'b0);
    chk("rst_drained", bus.drained, 1'b0);
    check_state("rst");

    // Single pair
    a_v = {8{20'h11111}}; b_v = {8{20'h22222}};
    send_pad(a_v, 1'b0);
    send_pad(b_v, 1'b1);
    check_state("single");
    chk("single_data", bus.pair_data, {a_v, b_v});
    chk("single_id", bus.pair_id, 32'd0);

    // Backpressure: fill, then a fifth opad must stall until a pop
    for (int i = 0; i < 3; i++) begin
      send_pad(rnd160(), 1'b0);
      send_pad(rnd160(), 1'b1);
    end
    check_state("full");
    send_pad(rnd160(), 1'b0);
    g_v = rnd160();
    bus.iopad_hash = g_v; bus.pad_type = 1'b1; bus.ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_stall", bus.hash_read, 1'b0);
    end
    chk("bp_count", bus.fifo_count, DEPTH);
    bus.pair_read = 1'b1;
    @(negedge clk);
    bus.pair_read = 1'b0;
    void'(mq.pop_front());
    chk("bp_no_ack_on_pop", bus.hash_read, 1'b0);
    @(negedge clk);
    chk("bp_ack", bus.hash_read, 1'b1);
    model_accept(g_v, 1'b1);
    check_state("bp_refill");
    release_pad();
    for (int i = 0; i < 3; i++) pop_one();
    chk("bp_id4", bus.pair_id, 32'd4);
    pop_one();

    // Order error: opad first is discarded but acknowledged
    c_v = rnd160();
    send_pad(c_v, 1'b1);
    check_state("oerr");
    a_v = rnd160(); b_v = rnd160();
    send_pad(a_v, 1'b0);
    send_pad(b_v, 1'b1);
    check_state("oerr_pair");
    chk("oerr_pair_data", bus.pair_data, {a_v, b_v});

    // Simultaneous push and pop at count 2 (pointers wrap here)
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send_pad(rnd160(), 1'b0);
      send_pad(rnd160(), 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      send_pad(rnd160(), 1'b0);
      g_v = rnd160();
      prev_id = mq[0].id;
      bus.iopad_hash = g_v; bus.pad_type = 1'b1; bus.ready = 1'b1; bus.pair_read = 1'b1;
      @(negedge clk);
      bus.pair_read = 1'b0;
      chk("sim_ack", bus.hash_read, 1'b1);
      void'(mq.pop_front());
      model_accept(g_v, 1'b1);
      check_state("sim");
      chk("sim_head_adv", bus.pair_id, prev_id + 32'd1);
      release_pad();
    end
    pop_one();
    pop_one();

    // Drain
    for (int i = 0; i < 2; i++) begin
      send_pad(rnd160(), 1'b0);
      send_pad(rnd160(), 1'b1);
    end
    bus.gen_finished = 1'b1;
    @(negedge clk);
    chk("drain_busy", bus.drained, 1'b0);
    pop_one();
    chk("drain_one_left", bus.drained, 1'b0);
    bus.pair_read = 1'b1;
    @(negedge clk);
    bus.pair_read = 1'b0;
    void'(mq.pop_front());
    chk("drain_at_pop", bus.drained, 1'b0);
    @(negedge clk);
    chk("drain_set", bus.drained, 1'b1);
    bus.gen_finished = 1'b0;
    @(negedge clk);
    chk("drain_clear", bus.drained, 1'b0);

    // Reset while in ACK with an ipad held
    send_pad(rnd160(), 1'b0);
    send_pad(rnd160(), 1'b1);
    bus.iopad_hash = rnd160(); bus.pad_type = 1'b0; bus.ready = 1'b1;
    acked = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.hash_read) begin acked = 1; break; end
    end
    chk("rst_ack_seen", acked, 1'b1);
    device_reset_n = 1'b0; bus.ready = 1'b0;
    @(negedge clk);
    chk("rst_ack_drop", bus.hash_read, 1'b0);
    chk("rst_ack_count", bus.fifo_count, 0);
    model_reset();
    device_reset_n = 1'b1;
    send_pad(rnd160(), 1'b1);
    check_state("rst_opad_first");

    // Randomized traffic with occasional ordering faults
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 3 && mq.size() != 0) begin
        pop_one();
      end else begin
        t = m_exp;
        if ($urandom_range(0, 9) == 0) t = ~t;
        if (t && m_exp && mq.size() == DEPTH) pop_one();
        send_pad(rnd160(), t);
        check_state("rand");
      end
    end
    while (mq.size() != 0) pop_one();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pad_pair_collector.md
# pad_pair_collector

Collects the ipad/opad SHA1 midstates emitted one at a time by the generation pipe and stores them as complete pairs in a small show-ahead FIFO. The PBKDF2 hasher core pops pairs from this FIFO. The block sits directly downstream of the generation pipe:

- It drives the pipe's `hash_read` acknowledge with a 4-phase level handshake.
- It tags every pair with a sequence id so a hit can be mapped back to its password.
- It reports when generation has finished and all queued pairs are consumed.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries. Must be a power of two, at least 2.
- `AW`, 2: log2(DEPTH), the pointer width.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `device_reset_n`  in  1  synchronous, active-low reset.
- `iopad_hash`  in  160  midstate from the generation pipe; stable while `ready` is high.
- `pad_type`  in  1  0 = ipad, 1 = opad.
- `ready`  in  1  the generation pipe has a midstate available.
- `gen_finished`  in  1  the generation pipe has produced its last password.
- `hash_read`  out  1  registered 4-phase acknowledge to the generation pipe.
- `pair_data`  out  320  {ipad[159:0], opad[159:0]} of the FIFO head.
- `pair_id`  out  32  sequence number of the FIFO head.
- `pair_valid`  out  1  FIFO is non-empty.
- `pair_read`  in  1  pop the head; ignored when `pair_valid` is 0.
- `fifo_count`  out  AW+1  number of stored pairs, 0..DEPTH.
- `order_error`  out  1  sticky flag: a pad arrived with an unexpected `pad_type`.
- `drained`  out  1  generation is finished and every pair has been consumed.

## Operation

- The handshake FSM has two states: WAIT and ACK. `hash_read` is 1 exactly when the FSM is in ACK.
  - WAIT: `ready` must be 1 and the accept condition must hold (below). On that edge the block acts on the midstate, then goes to ACK.
  - ACK: wait until `ready` is 0, then go to WAIT. No capture happens in ACK.
- A flag `expect_opad` tracks the pair position and resets to 0.
- Accept conditions in WAIT:
  - `pad_type`=0 and `expect_opad`=0: latch `iopad_hash` into the ipad holding register and set `expect_opad`=1. Always accepted.
  - `pad_type`=1 and `expect_opad`=1: accepted only if `fifo_count` < DEPTH. Push {ipad_hold, `iopad_hash`} with the current id counter, increment the id counter (mod 2^32), clear `expect_opad`.
  - `pad_type`=1 and `expect_opad`=0: set `order_error`, discard the midstate, still go to ACK.
  - `pad_type`=0 and `expect_opad`=1: set `order_error`, overwrite ipad_hold with the new midstate, keep `expect_opad`=1, go to ACK.
- When the FIFO is full, an opad is not acknowledged. `hash_read` stays 0, which stalls the generation pipe.
  - A pop in the same cycle does not free a slot for that cycle. The push is accepted on the following edge at the earliest.
- FIFO behaviour:
  - It is show-ahead: `pair_data`/`pair_id` always show the head entry and are valid while `pair_valid`=1.
  - A pop happens when `pair_read` & `pair_valid`.
  - Push and pop on the same edge: `fifo_count` is unchanged, order is preserved, and the head advances.
  - Pointers wrap modulo DEPTH.
- `drained` is registered. It is 1 when all of the following hold: `gen_finished`=1, `fifo_count`=0, FSM in WAIT, `expect_opad`=0, `ready`=0.
- Reset values (`device_reset_n`=0 sampled on a clock edge):
  - Outputs: `hash_read`=0, `pair_valid`=0, `fifo_count`=0, `order_error`=0, `drained`=0.
  - Internal state: id counter=0, `expect_opad`=0, FSM in WAIT.
  - Reset mid-handshake aborts: a held ipad is discarded and `hash_read` drops on that edge.

## Timing

- When `ready` is sampled high in WAIT and accepted at edge T, `hash_read`=1 after edge T.
- When `ready` is sampled low in ACK at edge U, `hash_read`=0 after edge U.
- The generation pipe synchronises `hash_read` through 2 flops. A full pad transfer therefore takes roughly 6–8 cycles; the collector adds 1 cycle in each direction.
- An opad accepted at edge T into an empty FIFO gives `pair_valid`=1 with the new data after edge T.
- A pop at edge T gives the new head (or `pair_valid`=0) after edge T.
- `drained` rises 1 cycle after its conditions first hold and falls 1 cycle after any of them fails.

## Test plan

- Single pair: ipad A=160'h1111… (`pad_type`=0), then opad B=160'h2222… → two full 4-phase `hash_read` cycles; `pair_data`={A,B}, `pair_id`=0, `fifo_count`=1.
- Backpressure, DEPTH=4: push 4 pairs with no pops → `fifo_count`=4. The 5th opad keeps `hash_read`=0 for 20 cycles. One pop → `hash_read`=1 no earlier than 2 edges after the pop; `fifo_count` returns to 4; the new pair has id 4.
- Order error: opad C first → `order_error`=1, `hash_read` still cycles, `fifo_count` stays 0. A following ipad D/opad E → pair {D,E}.
- Simultaneous push/pop at `fifo_count`=2 → count stays 2; head id advances by 1; ids pop in order 0,1,2 with data intact across the pointer wrap.
- Drain: 2 pairs queued with `gen_finished`=1 → `drained`=0 until the second pop, then `drained`=1 exactly 1 cycle after the last pop edge.
- Reset in ACK with ipad held → after the reset edge `hash_read`=0 and `fifo_count`=0. A subsequent opad-first sequence flags `order_error`.
